// File: rtl/cg_sched.sv
// cg_sched -- per-channel automatic clock-gating scheduler.
//
// Drives the EN pins of the ICG cells, one per gated clock domain. Each
// channel counts idle cycles, asks its owning block to quiesce, gates the
// clock once the block acknowledges, and ungates on activity with a fixed
// settle delay before reporting the clock ready. Channels are independent.
// Clocked by the ungated source clock that also feeds the ICG CK pins.
//
// Optional build macro: CGSCHED_STAT_EN adds per-channel gated-cycle
// counters (gated_cnt) with a synchronous clear (stat_clr).
//
// Ports:
//   clk           ungated source clock
//   reset         synchronous, active-high; every channel restarts in RUN
//   cfg_auto_en   [NCH]         per-channel auto-gating enable
//   cfg_force_on  [NCH]         per-channel override, keeps the clock running
//   cfg_idle_thr  [NCH*IDLE_W]  idle threshold, channel i at [i*IDLE_W +: IDLE_W]
//   busy          [NCH]         channel activity
//   wake_req      [NCH]         external wake request
//   quiesce_ack   [NCH]         block reports it is safe to stop
//   quiesce_req   [NCH]         request to the block to quiesce (registered)
//   cg_en         [NCH]         ICG enable (registered)
//   clk_rdy       [NCH]         gated clock stable and running (registered)
//   st_off        [NCH]         channel is gated off (registered)
//   gated_cnt     [NCH*32]      cycles spent gated (CGSCHED_STAT_EN only)
//   stat_clr      [NCH]         clear gated_cnt, wins over increment (CGSCHED_STAT_EN only)
//   state_dbg     [NCH*3]       FSM state per channel, channel i at [i*3 +: 3]
//
// Handshake: quiesce_req is a level request held until the channel either
// sees quiesce_ack (and gates) or sees activity (and aborts back to RUN).
// An ack coincident with activity loses; ack outside QREQ is ignored.

module cg_sched #(
  parameter int NCH      = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        cfg_auto_en,
  input  logic [NCH-1:0]        cfg_force_on,
  input  logic [NCH*IDLE_W-1:0] cfg_idle_thr,
  input  logic [NCH-1:0]        busy,
  input  logic [NCH-1:0]        wake_req,
  input  logic [NCH-1:0]        quiesce_ack,
  output logic [NCH-1:0]        quiesce_req,
  output logic [NCH-1:0]        cg_en,
  output logic [NCH-1:0]        clk_rdy,
  output logic [NCH-1:0]        st_off,
`ifdef CGSCHED_STAT_EN
  input  logic [NCH-1:0]        stat_clr,
  output logic [NCH*32-1:0]     gated_cnt,
`endif
  output logic [NCH*3-1:0]      state_dbg
);

  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_IDLE = 3'd1,
    S_QREQ = 3'd2,
    S_OFF  = 3'd3,
    S_WAKE = 3'd4
  } state_t;

  localparam int WCW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYC - 1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t            state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WCW-1:0]    wake_cnt_q, wake_cnt_d;
    logic [IDLE_W-1:0] thr;
    logic              stay_on;
    logic              qreq_q, cg_en_q, rdy_q, off_q;

    assign thr     = cfg_idle_thr[i*IDLE_W +: IDLE_W];
    // Activity or any hold condition keeps (or brings) the clock running.
    assign stay_on = busy[i] | wake_req[i] | cfg_force_on[i] | ~cfg_auto_en[i];

    always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      wake_cnt_d = wake_cnt_q;
      case (state_q)
        S_RUN: begin
          if (!stay_on) begin
            state_d    = S_IDLE;
            idle_cnt_d = '0;
          end
        end
        S_IDLE: begin
          // Activity beats the threshold compare; the compare uses the live
          // threshold so a config change applies immediately.
          if (stay_on) begin
            state_d = S_RUN;
          end else if (idle_cnt_q >= thr) begin
            state_d = S_QREQ;
          end else if (idle_cnt_q != '1) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
        S_QREQ: begin
          if (stay_on) begin
            state_d = S_RUN;
          end else if (quiesce_ack[i]) begin
            state_d = S_OFF;
          end
        end
        S_OFF: begin
          if (stay_on) begin
            state_d    = S_WAKE;
            wake_cnt_d = '0;
          end
        end
        S_WAKE: begin
          // Never aborted: the settle delay always runs to completion.
          if (wake_cnt_q == WAKE_LAST) begin
            state_d = S_RUN;
          end else begin
            wake_cnt_d = wake_cnt_q + 1'b1;
          end
        end
        default: state_d = S_RUN;
      endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so cg_en falls on the same edge that enters OFF with no comb path.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q    <= S_RUN;
        idle_cnt_q <= '0;
        wake_cnt_q <= '0;
        qreq_q     <= 1'b0;
        cg_en_q    <= 1'b1;
        rdy_q      <= 1'b1;
        off_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        idle_cnt_q <= idle_cnt_d;
        wake_cnt_q <= wake_cnt_d;
        qreq_q     <= (state_d == S_QREQ);
        cg_en_q    <= (state_d != S_OFF);
        rdy_q      <= (state_d == S_RUN) || (state_d == S_IDLE) || (state_d == S_QREQ);
        off_q      <= (state_d == S_OFF);
      end
    end

    assign quiesce_req[i]    = qreq_q;
    assign cg_en[i]          = cg_en_q;
    assign clk_rdy[i]        = rdy_q;
    assign st_off[i]         = off_q;
    assign state_dbg[i*3 +: 3] = state_q;

`ifdef CGSCHED_STAT_EN
    logic [31:0] gcnt_q;

    always_ff @(posedge clk) begin
      if (reset || stat_clr[i]) begin
        gcnt_q <= '0;
      end else if (state_q == S_OFF) begin
        gcnt_q <= gcnt_q + 32'd1;
      end
    end

    assign gated_cnt[i*32 +: 32] = gcnt_q;
`endif
  end

endmodule
